// File: rtl/i2s_mic_rx.sv
// ---------------------------------------------------------------------------
// i2s_mic_rx
//
// I2S master receiver for a 24-bit-in-32-slot MEMS microphone. The block
// generates the bit clock and word select from CLK, shifts in the serial data
// MSB first, and emits one signed 18-bit sample per frame from the selected
// channel. The sample comes with a one-CLK ready strobe.
//
// Parameters
//   CLK_DIV   CLK cycles per SCK half-period (>= 2); frame = 128*CLK_DIV CLK
//   CHANNEL   captured slot: 0 = left (WS low), 1 = right (WS high)
//   DC_SHIFT  DC-block time-constant shift (used with I2S_DCBLOCK_EN only)
//
// Optional feature
//   I2S_DCBLOCK_EN  when defined, a DC-blocking high-pass stage with a
//                   saturating output sits after capture, and the strobe
//                   comes one CLK later.
//
// Ports
//   CLK       in   system clock, all logic on posedge
//   nRST      in   synchronous active-low reset
//   I2S_SCK   out  bit clock to the microphone
//   I2S_WS    out  word select, 0 = left, 1 = right
//   I2S_SD    in   serial data from the microphone, MSB first
//   ADATA0    out  signed 18-bit sample, held between strobes
//   ADATARDY  out  one-CLK strobe, ADATA0 valid while high
// ---------------------------------------------------------------------------
module i2s_mic_rx #(
    parameter int CLK_DIV  = 22,
    parameter int CHANNEL  = 0,
    parameter int DC_SHIFT = 10
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        I2S_SCK,
    output logic        I2S_WS,
    input  logic        I2S_SD,
    output logic [17:0] ADATA0,
    output logic        ADATARDY
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("i2s_mic_rx: CLK_DIV must be at least 2");
        end
        if (DC_SHIFT < 0) begin : g_bad_shift
            $error("i2s_mic_rx: DC_SHIFT must not be negative");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [5:0]       bit_cnt_inc;
    logic [4:0]       slot_idx;
    logic [16:0]      shreg;     // the oldest bit is never needed, so 17 bits
    logic [17:0]      sample;
    logic             sd_q;
    logic             wrap;
    logic             rise;
    logic             fall;
    logic             in_slot;
    logic             capture;

    assign wrap        = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise        = wrap && !I2S_SCK;
    assign fall        = wrap && I2S_SCK;
    assign bit_cnt_inc = bit_cnt + 6'd1;
    assign slot_idx    = bit_cnt[4:0];
    // Index 0 is the I2S delay bit; 1..18 are sample MSB..LSB; the rest are
    // truncated LSBs of the 24-bit word.
    assign in_slot     = (bit_cnt[5] == 1'(CHANNEL)) &&
                         (slot_idx >= 5'd1) && (slot_idx <= 5'd18);
    assign capture     = rise && in_slot && (slot_idx == 5'd18);
    assign sample      = {shreg, sd_q};

    // Bit clock, frame counter and word select.
    // NOTE: every register here uses <= so all flops update from the same
    // pre-edge values; a blocking = would let later lines see new values.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            div_cnt <= '0;
            I2S_SCK <= 1'b0;
            bit_cnt <= '0;
            I2S_WS  <= 1'b0;
            sd_q    <= 1'b0;
        end else begin
            sd_q <= I2S_SD;
            if (wrap) begin
                div_cnt <= '0;
                I2S_SCK <= ~I2S_SCK;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            // WS follows the new counter MSB, so it flips on the falling edge
            // just before the delay bit of the next slot.
            if (fall) begin
                bit_cnt <= bit_cnt_inc;
                I2S_WS  <= bit_cnt_inc[5];
            end
        end
    end

    // NOTE: the shift register is a plain register, not a memory, so it is
    // cleared by reset like the rest of the datapath; a partial sample never
    // leaks across a reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            shreg <= '0;
        end else if (rise && in_slot) begin
            shreg <= sample[16:0];
        end
    end

`ifdef I2S_DCBLOCK_EN
    localparam int ACC_W = 18 + DC_SHIFT;
    localparam logic signed [ACC_W:0] Y_MAX = (ACC_W + 1)'(131071);
    localparam logic signed [ACC_W:0] Y_MIN = (ACC_W + 1)'(-131072);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sh;
    logic signed [ACC_W:0]   y_full;
    logic [17:0]             x_q;
    logic [17:0]             y_sat;
    logic                    x_vld;

    // One-pole high-pass: acc tracks x << DC_SHIFT, y is x minus that mean.
    assign acc_sh = acc >>> DC_SHIFT;
    assign y_full = $signed({{(ACC_W - 17){x_q[17]}}, x_q}) -
                    $signed({acc_sh[ACC_W-1], acc_sh});

    // NOTE: y_sat gets a default before the conditions, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        y_sat = y_full[17:0];
        if (y_full > Y_MAX) begin
            y_sat = 18'h1FFFF;
        end else if (y_full < Y_MIN) begin
            y_sat = 18'h20000;
        end
    end

    // The captured sample is registered first and filtered on the next CLK,
    // which is where the extra cycle of strobe latency comes from.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            x_q      <= '0;
            x_vld    <= 1'b0;
            acc      <= '0;
            ADATA0   <= '0;
            ADATARDY <= 1'b0;
        end else begin
            x_vld    <= capture;
            ADATARDY <= x_vld;
            if (capture) begin
                x_q <= sample;
            end
            if (x_vld) begin
                acc    <= acc + y_full[ACC_W-1:0];
                ADATA0 <= y_sat;
            end
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ADATA0   <= '0;
            ADATARDY <= 1'b0;
        end else begin
            ADATARDY <= capture;
            if (capture) begin
                ADATA0 <= sample;
            end
        end
    end
`endif

endmodule

// File: tb/tb_i2s_mic_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_mic_rx
//
// Two receivers (left and right channel) share one microphone model. The
// model drives SD on SCK falling edges and restarts its bit position whenever
// WS changes. For every selected-slot sample it queues the value and the CLK
// cycle at which the strobe is due. A DC-block reference is applied when
// I2S_DCBLOCK_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_mic_rx;

    localparam int CLK_DIV  = 22;
    localparam int DC_SHIFT = 1;
    localparam int FRAME    = 128 * CLK_DIV;
`ifdef I2S_DCBLOCK_EN
    localparam int LAT   = 1;
    localparam bit DC_ON = 1'b1;
`else
    localparam int LAT   = 0;
    localparam bit DC_ON = 1'b0;
`endif

    typedef struct {
        logic [17:0] left;
        logic [17:0] right;
        int          exp_l;   // signed value of left
        int          exp_r;   // signed value of right
    } frame_t;

    typedef struct {
        int val;
        int due;
    } exp_t;

    logic        clk  = 1'b0;
    logic        nrst = 1'b0;
    logic        sd   = 1'b0;
    logic        sck0, ws0, rdy0;
    logic        sck1, ws1, rdy1;
    logic [17:0] adata0, adata1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    frame_t      frame_q[$];
    frame_t      cur = '{left: 18'h0, right: 18'h0, exp_l: 0, exp_r: 0};
    exp_t        exp0_q[$];
    exp_t        exp1_q[$];
    longint      acc_m[2];
    logic [17:0] last_v[2];
    int          pos     = 0;
    logic        prev_ws = 1'b0;
    logic        prev_sck = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_mic_rx #(.CLK_DIV(CLK_DIV), .CHANNEL(0), .DC_SHIFT(DC_SHIFT)) dut0 (
        .CLK(clk), .nRST(nrst), .I2S_SCK(sck0), .I2S_WS(ws0), .I2S_SD(sd),
        .ADATA0(adata0), .ADATARDY(rdy0)
    );

    i2s_mic_rx #(.CLK_DIV(CLK_DIV), .CHANNEL(1), .DC_SHIFT(DC_SHIFT)) dut1 (
        .CLK(clk), .nRST(nrst), .I2S_SCK(sck1), .I2S_WS(ws1), .I2S_SD(sd),
        .ADATA0(adata1), .ADATARDY(rdy1)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // DC-block reference: y = x - mean, mean tracked as acc / 2^DC_SHIFT.
    function automatic int dc_step(input int ch, input int x);
        longint y;
        y = longint'(x) - (acc_m[ch] >>> DC_SHIFT);
        acc_m[ch] = acc_m[ch] + y;
        if (y > 131071)  y = 131071;
        if (y < -131072) y = -131072;
        return int'(y);
    endfunction

    task automatic score(input int ch, input logic rdy, input logic [17:0] data);
        exp_t e;
        bit   have;
        have = (ch == 0) ? (exp0_q.size() > 0) : (exp1_q.size() > 0);
        if (have) e = (ch == 0) ? exp0_q[0] : exp1_q[0];
        if (rdy) begin
            check(ch == 0 ? "strobe_expected_l" : "strobe_expected_r", have, 1);
            if (have) begin
                if (ch == 0) void'(exp0_q.pop_front());
                else         void'(exp1_q.pop_front());
                check(ch == 0 ? "strobe_time_l" : "strobe_time_r", cyc, e.due);
                check(ch == 0 ? "adata_l" : "adata_r", $signed(data), e.val);
            end
            last_v[ch] = data;
        end else begin
            check(ch == 0 ? "hold_l" : "hold_r", data, last_v[ch]);
            if (have && cyc > e.due) begin
                check(ch == 0 ? "missed_strobe_l" : "missed_strobe_r", cyc, e.due);
                if (ch == 0) void'(exp0_q.pop_front());
                else         void'(exp1_q.pop_front());
            end
        end
    endtask

    // Microphone model and scoreboard.
    always @(negedge clk) begin
        logic [17:0] s;
        exp_t        e;
        if (!nrst) begin
            check("pending_at_reset", exp0_q.size() + exp1_q.size(), 0);
            exp0_q.delete();
            exp1_q.delete();
            pos       = 0;
            prev_ws   = 1'b0;
            prev_sck  = 1'b0;
            acc_m[0]  = 0;
            acc_m[1]  = 0;
            last_v[0] = '0;
            last_v[1] = '0;
        end else begin
            score(0, rdy0, adata0);
            score(1, rdy1, adata1);
            if (prev_sck && !sck0) begin
                if (ws0 != prev_ws) pos = 0;
                else                pos++;
                prev_ws = ws0;
                if (!ws0 && pos == 1 && frame_q.size() > 0) cur = frame_q.pop_front();
                s = ws0 ? cur.right : cur.left;
                if (pos >= 1 && pos <= 18) sd = s[18 - pos];
                else                       sd = 1'($urandom);
                if (pos == 18) begin
                    e.due = cyc + CLK_DIV + LAT;
                    if (!ws0) begin
                        e.val = DC_ON ? dc_step(0, cur.exp_l) : cur.exp_l;
                        exp0_q.push_back(e);
                    end else begin
                        e.val = DC_ON ? dc_step(1, cur.exp_r) : cur.exp_r;
                        exp1_q.push_back(e);
                    end
                end
            end
            prev_sck = sck0;
        end
    end

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        frame_t tbl[6];
        frame_t f;
        int     rise1 = -1, rise2 = -1, fall1 = -1, wsr = -1, wsf = -1;
        logic   ps = 1'b0, pw = 1'b0;

        tbl[0] = '{left: 18'h12345, right: 18'h3FFFF, exp_l: 74565,   exp_r: -1};
        tbl[1] = '{left: 18'h20000, right: 18'h0ABCD, exp_l: -131072, exp_r: 43981};
        tbl[2] = '{left: 18'h1FFFF, right: 18'h00000, exp_l: 131071,  exp_r: 0};
        tbl[3] = '{left: 18'h00000, right: 18'h20000, exp_l: 0,       exp_r: -131072};
        tbl[4] = '{left: 18'h2AAAA, right: 18'h15555, exp_l: -87382,  exp_r: 87381};
        tbl[5] = '{left: 18'h00001, right: 18'h1FFFF, exp_l: 1,       exp_r: 131071};

        // Reset state.
        repeat (4) @(posedge clk);
        #1;
        check("rst_sck0", sck0, 0);
        check("rst_ws0", ws0, 0);
        check("rst_rdy0", rdy0, 0);
        check("rst_adata0", adata0, 0);
        check("rst_sck1", sck1, 0);
        check("rst_ws1", ws1, 0);
        check("rst_rdy1", rdy1, 0);
        check("rst_adata1", adata1, 0);

        for (int i = 0; i < 6; i++) frame_q.push_back(tbl[i]);
        for (int i = 0; i < 3; i++) begin
            f.left  = 18'($urandom);
            f.right = 18'($urandom);
            f.exp_l = int'($signed(f.left));
            f.exp_r = int'($signed(f.right));
            frame_q.push_back(f);
        end

        // Release and measure SCK / WS timing.
        nrst = 1'b1;
        for (int t = 1; t <= FRAME + 50; t++) begin
            @(posedge clk);
            #1;
            if (sck0 && !ps) begin
                if (rise1 < 0)      rise1 = t;
                else if (rise2 < 0) rise2 = t;
            end
            if (!sck0 && ps && fall1 < 0) fall1 = t;
            if (ws0 && !pw && wsr < 0)    wsr = t;
            if (!ws0 && pw && wsf < 0)    wsf = t;
            ps = sck0;
            pw = ws0;
        end
        check("first_sck_rise", rise1, CLK_DIV);
        check("first_sck_fall", fall1, 2 * CLK_DIV);
        check("sck_period", rise2 - rise1, 2 * CLK_DIV);
        check("ws_rise", wsr, FRAME / 2);
        check("ws_fall", wsf, FRAME);

        // Table and random frames run through the scoreboard.
        for (int t = 0; t < 12 * FRAME && frame_q.size() != 0; t++) @(posedge clk);
        check("table_consumed", frame_q.size(), 0);
        repeat (FRAME) @(posedge clk);

        // Reset in the middle of the left slot, at index 10.
        f = '{left: 18'h3C3C3, right: 18'h01234, exp_l: -15421, exp_r: 4660};
        frame_q.push_back(f);
        for (int t = 0; t < 3 * FRAME; t++) begin
            @(posedge clk);
            #1;
            if (frame_q.size() == 0 && pos == 10 && !ws0) break;
        end
        check("left_idx10_reached", pos, 10);
        nrst = 1'b0;
        frame_q.push_back('{left: 18'h0ABCD, right: 18'd1000, exp_l: 43981, exp_r: 1000});
        for (int i = 0; i < 10; i++)
            frame_q.push_back('{left: 18'd1000, right: 18'd1000, exp_l: 1000, exp_r: 1000});
        repeat (3) @(posedge clk);
        #1;
        check("midrst_sck0", sck0, 0);
        check("midrst_ws0", ws0, 0);
        check("midrst_rdy0", rdy0, 0);
        check("midrst_adata0", adata0, 0);
        nrst = 1'b1;

        // Post-reset frames: 0ABCD on the left, then constant 1000.
        for (int t = 0; t < 13 * FRAME && frame_q.size() != 0; t++) @(posedge clk);
        check("const_consumed", frame_q.size(), 0);
        repeat (FRAME) @(posedge clk);
        for (int t = 0; t < 2 * FRAME && (exp0_q.size() + exp1_q.size()) != 0; t++)
            @(posedge clk);
        #1;
        check("queues_drained", exp0_q.size() + exp1_q.size(), 0);
        if (DC_ON) begin
            check("dc_settled_r", ($signed(adata1) <= 2 && $signed(adata1) >= -2), 1);
        end else begin
            check("const_l", $signed(adata0), 1000);
            check("const_r", $signed(adata1), 1000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_mic_rx.md
Name: i2s_mic_rx

Overview:
- I2S master receiver for a MEMS microphone (INMP441-class, 24-bit-in-32-slot I2S). Produces the signed 18-bit audio sample stream and one-cycle ready strobe consumed by the spectrogram/LCD block on ADATA0/ADATARDY.
- Generates the bit clock and word select from the system clock, shifts in serial data, and emits one sample per frame from the selected channel.

Parameters:
- CLK_DIV, 22, CLK cycles per SCK half-period; minimum 2. Frame = 64 SCK = 128*CLK_DIV CLK; at 90 MHz this is 2816 CLK, about 31.96 kHz.
- CHANNEL, 0, captured slot: 0 = left (WS low), 1 = right (WS high).
- DC_SHIFT, 10, DC-block time-constant shift; used only with the optional feature.

Ports:
- CLK  in  1  system clock; all logic is on its posedge.
- nRST  in  1  synchronous active-low reset.
- I2S_SCK  out  1  bit clock to the microphone.
- I2S_WS  out  1  word select: 0 = left, 1 = right.
- I2S_SD  in  1  serial data from the microphone, MSB first.
- ADATA0  out  18  signed sample; holds its value between strobes.
- ADATARDY  out  1  one-CLK strobe; ADATA0 is valid while it is high.

Behaviour:
- Reset (nRST=0 at posedge): div_cnt=0, I2S_SCK=0, bit_cnt(6b)=0, I2S_WS=0, shift register=0, ADATA0=0, ADATARDY=0. Any partial sample is discarded.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. At div_cnt==CLK_DIV-1, I2S_SCK toggles.
  - rise strobe = wrap while I2S_SCK==0.
  - fall strobe = wrap while I2S_SCK==1.
  - The first SCK rising edge is CLK_DIV cycles after reset release.
- Frame counter: bit_cnt increments on each fall strobe and wraps 63->0. I2S_WS is a registered copy of bit_cnt[5], updated on the same fall strobe. WS therefore changes on the SCK falling edge one bit before the MSB, per the I2S standard.
- Slot bit index is bit_cnt[4:0]:
  - Index 0 is the I2S delay bit and is ignored.
  - Indices 1..18 carry sample MSB..LSB.
  - Indices 19..31 are ignored (truncated LSBs).
- Input sampling: I2S_SD passes through one CLK flop (sd_q). sd_q is sampled only on the rise strobe, and only when bit_cnt[5]==CHANNEL and index is in 1..18: shreg <= {shreg[16:0], sd_q}.
- Sample output: on the rise strobe with index==18 in the selected slot, at the same CLK edge:
  - ADATA0 <= {shreg[16:0], sd_q}, interpreted as two's complement.
  - ADATARDY <= 1.
- ADATARDY returns to 0 on the next CLK. Exactly one strobe per 128*CLK_DIV CLK; the strobe never lasts 2 cycles.
- The non-selected slot is clocked through but never updates shreg or the outputs.
- Reset mid-frame: everything returns to reset values at that edge. After release, the frame restarts at bit_cnt=0 (left delay bit). The first strobe arrives no earlier than a complete slot.
- CLK_DIV<2 is illegal. Simulation issues $error at elaboration.

Optional Feature:
- Macro: I2S_DCBLOCK_EN.
- Defined: a DC-blocking stage is inserted after sample capture.
  - Signed accumulator acc, 18+DC_SHIFT bits, reset to 0.
  - On each captured sample x: acc <= acc + x - (acc>>>DC_SHIFT); y = x - (acc>>>DC_SHIFT), using the pre-update acc.
  - y saturates to [-131072, 131071] and is driven on ADATA0.
  - ADATARDY is delayed by exactly 1 CLK relative to the undefined build. Strobe spacing is unchanged.
- Undefined: no accumulator. ADATA0 is the raw captured sample with the timing stated above.

Test Plan:
- Reset, CLK_DIV=22 -> I2S_SCK period 44 CLK; first rise 22 CLK after release; I2S_WS period 2816 CLK, low for the first 1408; ADATA0=0 and ADATARDY=0 until the first capture.
- Bench mic model, CHANNEL=0, left=18'h12345 (random bits 19..31), right=18'h3FFFF -> ADATA0==18'h12345, ADATARDY pulses exactly 1 cycle, every 2816 CLK; right data never appears.
- CHANNEL=1, same stimulus -> ADATA0==18'h3FFFF (-1), strobe in the WS-high half only.
- Left=18'h20000 then 18'h1FFFF on consecutive frames -> ADATA0 reads -131072 then +131071, each with one strobe.
- nRST low for 3 CLK while in the left slot at index 10 -> no strobe for that frame; I2S_SCK=0, I2S_WS=0 during reset; the next frame captures 18'h0ABCD correctly.
- I2S_DCBLOCK_EN defined, constant input 1000 for 8192 frames -> first output 1000, final |ADATA0|<=2, strobe 1 CLK later than the undefined build. Undefined build -> ADATA0==1000 throughout.
